// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the program-ROM loader.
// Holds the loader FSM state encoding and the default frame/ROM limits.
// No logic; imported by rom_loader and its sub-modules.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  // Default frame start byte.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Largest ROM the 8-bit length field can describe.
  localparam int MAX_DEPTH = 255;

endpackage

// File: rtl/rom_loader_timer.sv
// Idle-cycle counter used to abort stalled frames.
// Ports: clk/rst (sync, active-high), clr (zero the count), en (count one cycle),
//        expired (count has reached TIMEOUT; held there until cleared).
module rom_loader_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_q;

  assign expired = (count_q == TW'(TIMEOUT));

  // Saturates at TIMEOUT so a missed clear can never wrap back to a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + TW'(1);
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Converts a framed byte stream (sync, length, payload[, checksum]) into ROM write cycles.
// Latency: payload byte accepted in cycle t is written (wen_o) in cycle t+1.
// Backpressure: s_ready_o is registered; low only in the DONE/ERR cycle and the first cycle after reset.
// Ports: clk, rst (sync, active-high); s_valid_i/s_data_i/s_ready_o byte stream;
//        wen_o/w_addr_o/w_data_o ROM write port; busy_o, done_o (sticky ok), err_o (sticky abort).
// Build option: ROM_LOADER_CHECKSUM_EN adds the trailing checksum byte and its compare.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         AW      = 7,
  parameter int         DEPTH   = 128,   // must not exceed MAX_DEPTH
  parameter int         TIMEOUT = 1023,
  parameter logic [7:0] SYNC    = SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  output logic        wen_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  loader_state_t state_q, state_d;

  logic          s_ready_q;
  logic          wen_q;
  logic [AW-1:0] w_addr_q;
  logic [7:0]    w_data_q;
  logic          done_q, err_q;
  logic [7:0]    len_q;
  logic [7:0]    cnt_q;      // payload bytes written so far in this frame
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif

  logic accept, busy, tmo;
  logic sync_take, len_take, data_take, last_byte, len_bad;

  assign accept    = s_valid_i & s_ready_q;
  assign busy      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign len_bad   = (s_data_i == 8'd0) || (s_data_i > 8'(DEPTH));
  assign last_byte = ((cnt_q + 8'd1) == len_q);

  // A timeout wins over a byte arriving in the same cycle: the frame is dead.
  assign sync_take = accept && (state_q == ST_IDLE) && (s_data_i == SYNC);
  assign len_take  = accept && (state_q == ST_LEN) && !tmo;
  assign data_take = accept && (state_q == ST_DATA) && !tmo;

  rom_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept || !busy || (state_d != state_q)),
    .en      (busy),
    .expired (tmo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sync_take) state_d = ST_LEN;
      ST_LEN: begin
        if (tmo)           state_d = ST_ERR;
        else if (len_take) state_d = len_bad ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (tmo) state_d = ST_ERR;
        else if (data_take && last_byte) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (tmo)         state_d = ST_ERR;
        else if (accept) state_d = (s_data_i == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_q <= 1'b0;
      wen_q     <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      // Ready tracks the state being entered so DONE/ERR see it low.
      s_ready_q <= (state_d != ST_DONE) && (state_d != ST_ERR);
      wen_q     <= data_take;
      if (data_take) begin
        w_addr_q <= cnt_q[AW-1:0];
        w_data_q <= s_data_i;
      end
      if (len_take) len_q <= s_data_i;
      if (sync_take) begin
        cnt_q  <= '0;
        done_q <= 1'b0;
        err_q  <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_q  <= '0;
`endif
      end else if (data_take) begin
        cnt_q <= cnt_q + 8'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_q <= sum_q + s_data_i;
`endif
      end
      if (state_d == ST_DONE) done_q <= 1'b1;
      if (state_d == ST_ERR)  err_q  <= 1'b1;
    end
  end

  assign s_ready_o = s_ready_q;
  assign wen_o     = wen_q;
  assign w_addr_o  = {{(32-AW){1'b0}}, w_addr_q};
  assign w_data_o  = {24'd0, w_data_q};
  assign busy_o    = busy;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: drives frames on the byte stream and
// checks ROM writes and status flags against hand-computed values.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid_i = 1'b0;
  logic [7:0]  s_data_i = 8'd0;
  logic        s_ready_o, wen_o, busy_o, done_o, err_o;
  logic [31:0] w_addr_o, w_data_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  rom_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_ready_o (s_ready_o),
    .wen_o     (wen_o),
    .w_addr_o  (w_addr_o),
    .w_data_o  (w_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wen_o === 1'b1) begin
      wr_addr.push_back(int'(w_addr_o));
      wr_data.push_back(int'(w_data_o));
      wr_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called on a falling edge; returns on the falling edge after the byte is taken.
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    s_valid_i = 1'b1;
    s_data_i  = b;
    while (s_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready: s_ready_o=%b for byte %h, required 1", s_ready_o, b);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", s_ready_o); end
    n_checks++; if (wen_o !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b, required 0", wen_o); end
    n_checks++; if (w_addr_o !== 32'd0) begin n_fail++; $display("FAIL rst_addr: got %h, required 0", w_addr_o); end
    n_checks++; if (w_data_o !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", w_data_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", done_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", err_o); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise: got %b, required 1", s_ready_o); end
  endtask

  task automatic test_good_frame();
    clear_log();
    send(8'hA5);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b, required 1", busy_o); end
    send(8'h03); send(8'h11); send(8'h22); send(8'h33);
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'h66);
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr.size() != 3) begin
      n_fail++; $display("FAIL good_nwr: got %0d writes, required 3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (wr_addr[i] != i) begin n_fail++; $display("FAIL good_addr%0d: got %0d, required %0d", i, wr_addr[i], i); end
        n_checks++; if (wr_data[i] != 'h11 * (i + 1)) begin n_fail++; $display("FAIL good_data%0d: got %h, required %h", i, wr_data[i], 'h11 * (i + 1)); end
      end
      n_checks++; if (wr_cyc[2] - wr_cyc[0] != 2) begin n_fail++; $display("FAIL good_b2b: write span %0d cycles, required 2", wr_cyc[2] - wr_cyc[0]); end
    end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL good_done: got %b, required 1", done_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL good_err: got %b, required 0", err_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL good_busy_end: got %b, required 0", busy_o); end
  endtask

`ifdef ROM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    clear_log();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h67);
    repeat (3) @(negedge clk);
    n_checks++; if (wr_addr.size() != 3) begin n_fail++; $display("FAIL csum_nwr: got %0d writes, required 3", wr_addr.size()); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL csum_err: got %b, required 1", err_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL csum_done: got %b, required 0", done_o); end
  endtask
`endif

  task automatic test_bad_len();
    logic [7:0] lens [2];
    lens[0] = 8'h00;
    lens[1] = 8'h81;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      send(8'hA5);
      n_checks++; if (err_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL len%0d_clear: done=%b err=%b, required 0 0", k, done_o, err_o); end
      send(lens[k]);
      n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL len%0d_err: got %b, required 1", k, err_o); end
      repeat (3) @(negedge clk);
      n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL len%0d_nwr: got %0d writes, required 0", k, wr_addr.size()); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL len%0d_done: got %b, required 0", k, done_o); end
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_log();
    send(8'hA5); send(8'h02); send(8'h10);
    // 1023 idle cycles reach the limit, err_o follows one cycle later.
    k = 0;
    while (err_o !== 1'b1 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k != 1024) begin n_fail++; $display("FAIL tmo_delay: err after %0d cycles, required 1024", k); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b, required 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL tmo_done: got %b, required 0", done_o); end
    n_checks++;
    if (wr_addr.size() != 1) begin
      n_fail++; $display("FAIL tmo_nwr: got %0d writes, required 1", wr_addr.size());
    end else begin
      n_checks++; if (wr_addr[0] != 0 || wr_data[0] != 'h10) begin n_fail++; $display("FAIL tmo_wr: got addr %0d data %h, required 0 10", wr_addr[0], wr_data[0]); end
    end
  endtask

  task automatic test_full_frame();
    int sum;
    int bad;
    clear_log();
    send(8'h00); send(8'hFF); send(8'h12);
    send(8'hA5); send(8'h80);
    sum = 0;
    for (int i = 0; i < 128; i++) begin
      send(8'(i));
      sum += i;
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'(sum));   // 8128 mod 256 = C0
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr.size() != 128) begin
      n_fail++; $display("FAIL full_nwr: got %0d writes, required 128", wr_addr.size());
    end else begin
      bad = -1;
      for (int i = 0; i < 128; i++)
        if (bad < 0 && (wr_addr[i] != i || wr_data[i] != i)) bad = i;
      n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL full_wr: entry %0d got addr %0d data %h, required %0d %h", bad, wr_addr[bad], wr_data[bad], bad, bad); end
    end
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b, required 1", done_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b, required 0", err_o); end
  endtask

  task automatic test_reset_midframe();
    clear_log();
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ready_o !== 1'b0 || wen_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: ready=%b wen=%b busy=%b, required 0 0 0", s_ready_o, wen_o, busy_o); end
    n_checks++; if (w_addr_o !== 32'd0 || w_data_o !== 32'd0) begin n_fail++; $display("FAIL mid_rst_bus: addr=%h data=%h, required 0 0", w_addr_o, w_data_o); end
    n_checks++; if (done_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: done=%b err=%b, required 0 0", done_o, err_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL mid_nwr: got %0d writes, required 2", wr_addr.size()); end
    clear_log();
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB);
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'h65);
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr.size() != 2) begin
      n_fail++; $display("FAIL mid_reload_nwr: got %0d writes, required 2", wr_addr.size());
    end else begin
      n_checks++; if (wr_addr[0] != 0 || wr_data[0] != 'hAA) begin n_fail++; $display("FAIL mid_reload_wr0: got %0d %h, required 0 aa", wr_addr[0], wr_data[0]); end
      n_checks++; if (wr_addr[1] != 1 || wr_data[1] != 'hBB) begin n_fail++; $display("FAIL mid_reload_wr1: got %0d %h, required 1 bb", wr_addr[1], wr_data[1]); end
    end
    n_checks++; if (done_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL mid_reload_flags: done=%b err=%b, required 1 0", done_o, err_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
`ifdef ROM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_bad_len();
    test_timeout();
    test_full_frame();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
